execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline; consumes the ID/EX bundle driven by decode and registers the EX/MEM bundle consumed by the memory stage.
- Performs ALU-control decode, ALU operand select, ALU operation, destination-register select and branch-target add.
- Holds all results in the EX/MEM pipeline register, with stall and flush support.

Parameters:
- DATA_W, 32, datapath width. Only 32 is supported.
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ex_stall  in  1  hold the EX/MEM register
- ex_flush  in  1  load a bubble (zero control) into EX/MEM
- id_ex_wb  in  2  {RegWrite, MemtoReg}
- id_ex_mem  in  3  {Branch, MemRead, MemWrite}
- id_ex_execute  in  4  {RegDst, ALUOp[1:0], ALUSrc}
- id_ex_npc  in  32  PC+4 of the instruction
- id_ex_readdat1  in  32  rs value
- id_ex_readdat2  in  32  rt value
- id_ex_sign_ext  in  32  sign-extended immediate; bits [5:0] carry funct
- id_ex_instr_bits_20_16  in  5  rt
- id_ex_instr_bits_15_11  in  5  rd
- ex_mem_wb  out  2  registered WB controls
- ex_mem_m  out  3  registered MEM controls
- ex_mem_add_result  out  32  branch target
- ex_mem_zero  out  1  ALU result == 0
- ex_mem_alu_result  out  32  ALU result
- ex_mem_rdata2  out  32  store data (id_ex_readdat2)
- ex_mem_write_reg  out  5  destination register

Behaviour:
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N; there is no combinational input-to-output path.
- Reset: every output is 0 on the edge where rst=1.
- Priority per edge: rst > ex_flush > ex_stall > normal load.
- ex_flush: ex_mem_wb and ex_mem_m load 0. Data fields load normally.
- ex_stall (no flush): all outputs hold their values.
- Operand B: id_ex_sign_ext if ALUSrc=1, else id_ex_readdat2.
- Write register: rd if RegDst=1, else rt.
- Branch target: add_result = npc + (sign_ext << 2), mod 2^32, wraps silently.
- ALU control from ALUOp:
  - 00 gives add.
  - 01 gives sub.
  - 10 decodes funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x27 nor.
  - 11, or an unlisted funct, gives the "pass zero" code; the result is 0 and zero=1.
- ALU control codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, ZERO 1111.
- Arithmetic: add/sub are mod 2^32 and ignore overflow. slt is a signed compare and returns 32'd1 or 32'd0.
- zero is computed from the final ALU result and registered with it.
- Reset asserted mid-stream discards the in-flight instruction. The first load after reset deasserts is the next presented input.

Optional Feature:
- Macro: EX_OVERFLOW_EN.
- Defined:
  - Adds output ex_mem_overflow (1 bit, reset 0, obeys stall hold; a flush loads 0).
  - It is set when a signed add/sub overflows under ALUOp=10.
  - When it is set, the registered RegWrite (ex_mem_wb[1]) is forced to 0.
- Undefined: the port is absent and overflow is ignored.

Decomposition:
- Package mips_pkg holds:
  - ALUOp encodings
  - funct constants
  - 4-bit ALU control codes
  - bit indices for the wb/mem/execute control fields
- One sub-module, ex_alu: purely combinational ALU-control decode plus the ALU. It takes ALUOp, funct, A and B, and returns result, zero and overflow.
- Muxes, adder and pipeline register stay in execute_stage.

Test Plan:
- R add:
  - Stimulus: execute=1100, rd1=0x11111111, rd2=0x22222222, sign_ext=0x00001820, rt=2, rd=3, wb=10.
  - Response: alu=0x33333333, zero=0, write_reg=3, wb=10, m=000.
- LW:
  - Stimulus: execute=0001, rd1=0x11111111, sign_ext=0xFFFFFFF8, rt=4, wb=11, mem=010.
  - Response: alu=0x11111109, write_reg=4, m=010, wb=11.
- BEQ:
  - Stimulus: execute=0010, rd1=rd2=0x22222222, npc=0x0000100C, sign_ext=0x4, mem=100.
  - Response: add_result=0x0000101C, zero=1, alu=0, m=100.
- SLT / SUB:
  - funct 0x2A, rd1=0xFFFFFFFF, rd2=1 gives alu=1.
  - funct 0x22, rd1=1, rd2=2 gives alu=0xFFFFFFFF, zero=0.
  - funct 0x3F gives alu=0, zero=1.
- Stall/flush:
  - Load the add from scenario 1, then assert stall with LW inputs: outputs hold 0x33333333 and write_reg=3.
  - Assert flush+stall: wb=00, m=000, alu=0x11111109.
- Reset mid-stream:
  - rst=1 during a BEQ gives all outputs 0 on that edge.
  - Release rst: the next instruction passes normally.
  - With EX_OVERFLOW_EN: 0x7FFFFFFF+1 gives overflow=1 and wb[1]=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: ALUOp values, funct codes, ALU control
// codes and bit positions inside the wb/mem/execute control bundles.
package mips_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ZERO  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_ZERO = 4'b1111;

  localparam int WB_REGWRITE  = 1;
  localparam int WB_MEMTOREG  = 0;
  localparam int MEM_BRANCH   = 2;
  localparam int MEM_MEMREAD  = 1;
  localparam int MEM_MEMWRITE = 0;
  localparam int EX_REGDST    = 3;
  localparam int EX_ALUOP_HI  = 2;
  localparam int EX_ALUOP_LO  = 1;
  localparam int EX_ALUSRC    = 0;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU-control decode and ALU for the EX stage; the overflow flag
// is only meaningful for R-type add/sub.
module ex_alu
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow
);

  logic [3:0]        alu_ctrl_s;
  logic [DATA_W-1:0] sum_s;
  logic [DATA_W-1:0] diff_s;

  assign sum_s  = a + b;
  assign diff_s = a - b;

  // ALUOp/funct to ALU control code; anything unrecognised passes zero
  always_comb begin
    alu_ctrl_s = ALU_ZERO;
    case (alu_op)
      ALUOP_ADD: alu_ctrl_s = ALU_ADD;
      ALUOP_SUB: alu_ctrl_s = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_ctrl_s = ALU_ADD;
          FUNCT_SUB: alu_ctrl_s = ALU_SUB;
          FUNCT_AND: alu_ctrl_s = ALU_AND;
          FUNCT_OR:  alu_ctrl_s = ALU_OR;
          FUNCT_SLT: alu_ctrl_s = ALU_SLT;
          FUNCT_NOR: alu_ctrl_s = ALU_NOR;
          default:   alu_ctrl_s = ALU_ZERO;
        endcase
      end
      default: alu_ctrl_s = ALU_ZERO;
    endcase
  end

  // ALU datapath
  always_comb begin
    result = {DATA_W{1'b0}};
    case (alu_ctrl_s)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = sum_s;
      ALU_SUB: result = diff_s;
      ALU_SLT: result = ($signed(a) < $signed(b)) ? {{(DATA_W-1){1'b0}}, 1'b1} : {DATA_W{1'b0}};
      ALU_NOR: result = ~(a | b);
      default: result = {DATA_W{1'b0}};
    endcase
  end

  assign zero = (result == {DATA_W{1'b0}});

  // Signed overflow: operand signs vs. result sign
  always_comb begin
    overflow = 1'b0;
    if (alu_op == ALUOP_RTYPE) begin
      case (alu_ctrl_s)
        ALU_ADD: overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum_s[DATA_W-1] != a[DATA_W-1]);
        ALU_SUB: overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff_s[DATA_W-1] != a[DATA_W-1]);
        default: overflow = 1'b0;
      endcase
    end else begin
      overflow = 1'b0;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: operand/destination muxes, branch-target adder, ALU and the EX/MEM
// register. Defining EX_OVERFLOW_EN adds ex_mem_overflow and suppresses RegWrite on overflow.
module execute_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_stall,
  input  logic              ex_flush,
  input  logic [1:0]        id_ex_wb,
  input  logic [2:0]        id_ex_mem,
  input  logic [3:0]        id_ex_execute,
  input  logic [DATA_W-1:0] id_ex_npc,
  input  logic [DATA_W-1:0] id_ex_readdat1,
  input  logic [DATA_W-1:0] id_ex_readdat2,
  input  logic [DATA_W-1:0] id_ex_sign_ext,
  input  logic [REG_AW-1:0] id_ex_instr_bits_20_16,
  input  logic [REG_AW-1:0] id_ex_instr_bits_15_11,
  output logic [1:0]        ex_mem_wb,
  output logic [2:0]        ex_mem_m,
  output logic [DATA_W-1:0] ex_mem_add_result,
  output logic              ex_mem_zero,
  output logic [DATA_W-1:0] ex_mem_alu_result,
  output logic [DATA_W-1:0] ex_mem_rdata2,
`ifdef EX_OVERFLOW_EN
  output logic              ex_mem_overflow,
`endif
  output logic [REG_AW-1:0] ex_mem_write_reg
);

  logic [DATA_W-1:0] alu_b_s;
  logic [DATA_W-1:0] alu_result_s;
  logic [DATA_W-1:0] add_result_s;
  logic [REG_AW-1:0] write_reg_s;
  logic [1:0]        wb_next_s;
  logic              zero_s;
  logic              overflow_s;

  assign alu_b_s      = id_ex_execute[EX_ALUSRC] ? id_ex_sign_ext : id_ex_readdat2;
  assign write_reg_s  = id_ex_execute[EX_REGDST] ? id_ex_instr_bits_15_11 : id_ex_instr_bits_20_16;
  assign add_result_s = id_ex_npc + {id_ex_sign_ext[DATA_W-3:0], 2'b00};

  ex_alu #(.DATA_W(DATA_W)) u_alu (
    .alu_op   (id_ex_execute[EX_ALUOP_HI:EX_ALUOP_LO]),
    .funct    (id_ex_sign_ext[5:0]),
    .a        (id_ex_readdat1),
    .b        (alu_b_s),
    .result   (alu_result_s),
    .zero     (zero_s),
    .overflow (overflow_s)
  );

`ifdef EX_OVERFLOW_EN
  // An overflowing R-type add/sub must not write the register file
  assign wb_next_s = {id_ex_wb[WB_REGWRITE] & ~overflow_s, id_ex_wb[WB_MEMTOREG]};
`else
  logic unused_overflow_s;
  assign unused_overflow_s = overflow_s;
  assign wb_next_s         = id_ex_wb;
`endif

  // EX/MEM pipeline register: reset > flush (bubble controls, data loads) > stall > load
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_wb         <= 2'b00;
      ex_mem_m          <= 3'b000;
      ex_mem_add_result <= {DATA_W{1'b0}};
      ex_mem_zero       <= 1'b0;
      ex_mem_alu_result <= {DATA_W{1'b0}};
      ex_mem_rdata2     <= {DATA_W{1'b0}};
      ex_mem_write_reg  <= {REG_AW{1'b0}};
`ifdef EX_OVERFLOW_EN
      ex_mem_overflow   <= 1'b0;
`endif
    end else if (ex_flush) begin
      ex_mem_wb         <= 2'b00;
      ex_mem_m          <= 3'b000;
      ex_mem_add_result <= add_result_s;
      ex_mem_zero       <= zero_s;
      ex_mem_alu_result <= alu_result_s;
      ex_mem_rdata2     <= id_ex_readdat2;
      ex_mem_write_reg  <= write_reg_s;
`ifdef EX_OVERFLOW_EN
      ex_mem_overflow   <= 1'b0;
`endif
    end else if (ex_stall) begin
      ex_mem_wb         <= ex_mem_wb;
      ex_mem_m          <= ex_mem_m;
      ex_mem_add_result <= ex_mem_add_result;
      ex_mem_zero       <= ex_mem_zero;
      ex_mem_alu_result <= ex_mem_alu_result;
      ex_mem_rdata2     <= ex_mem_rdata2;
      ex_mem_write_reg  <= ex_mem_write_reg;
`ifdef EX_OVERFLOW_EN
      ex_mem_overflow   <= ex_mem_overflow;
`endif
    end else begin
      ex_mem_wb         <= wb_next_s;
      ex_mem_m          <= id_ex_mem;
      ex_mem_add_result <= add_result_s;
      ex_mem_zero       <= zero_s;
      ex_mem_alu_result <= alu_result_s;
      ex_mem_rdata2     <= id_ex_readdat2;
      ex_mem_write_reg  <= write_reg_s;
`ifdef EX_OVERFLOW_EN
      ex_mem_overflow   <= overflow_s;
`endif
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, stall/flush/reset
// sequences and a randomized run against an arithmetic reference model.
module tb_execute_stage;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [3:0]  exe;
    logic [31:0] npc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] se;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } in_t;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] add;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] rdata2;
    logic [4:0]  wreg;
    logic        ovf;
  } out_t;

  typedef struct {
    in_t         in;
    logic [31:0] e_alu;
    logic        e_zero;
    logic [4:0]  e_wreg;
    logic [31:0] e_add;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, ex_stall, ex_flush;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_mem;
  logic [3:0]  id_ex_execute;
  logic [31:0] id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext;
  logic [4:0]  id_ex_instr_bits_20_16, id_ex_instr_bits_15_11;
  logic [1:0]  ex_mem_wb;
  logic [2:0]  ex_mem_m;
  logic [31:0] ex_mem_add_result, ex_mem_alu_result, ex_mem_rdata2;
  logic        ex_mem_zero;
  logic [4:0]  ex_mem_write_reg;
`ifdef EX_OVERFLOW_EN
  logic        ex_mem_overflow;
`endif

  int checks = 0;
  int failures = 0;
  out_t exp_q;
  vec_t vecs[12];

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst(rst), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .id_ex_wb(id_ex_wb), .id_ex_mem(id_ex_mem), .id_ex_execute(id_ex_execute),
    .id_ex_npc(id_ex_npc), .id_ex_readdat1(id_ex_readdat1), .id_ex_readdat2(id_ex_readdat2),
    .id_ex_sign_ext(id_ex_sign_ext),
    .id_ex_instr_bits_20_16(id_ex_instr_bits_20_16), .id_ex_instr_bits_15_11(id_ex_instr_bits_15_11),
    .ex_mem_wb(ex_mem_wb), .ex_mem_m(ex_mem_m), .ex_mem_add_result(ex_mem_add_result),
    .ex_mem_zero(ex_mem_zero), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_rdata2(ex_mem_rdata2),
`ifdef EX_OVERFLOW_EN
    .ex_mem_overflow(ex_mem_overflow),
`endif
    .ex_mem_write_reg(ex_mem_write_reg)
  );

  // Reference: instruction semantics computed with wide signed arithmetic
  function automatic out_t model(input in_t v);
    out_t o;
    logic [31:0] a, b;
    longint sa, sb, wide;
    logic ovf;
    a = v.rd1;
    b = v.exe[0] ? v.se : v.rd2;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ovf = 1'b0;
    o.alu = 32'd0;
    case (v.exe[2:1])
      2'd0: o.alu = a + b;
      2'd1: o.alu = a - b;
      2'd2: begin
        case (v.se[5:0])
          6'h20: begin o.alu = a + b; wide = sa + sb; ovf = (wide != longint'($signed(o.alu))); end
          6'h22: begin o.alu = a - b; wide = sa - sb; ovf = (wide != longint'($signed(o.alu))); end
          6'h24: o.alu = a & b;
          6'h25: o.alu = a | b;
          6'h27: o.alu = ~(a | b);
          6'h2A: o.alu = (sa < sb) ? 32'd1 : 32'd0;
          default: o.alu = 32'd0;
        endcase
      end
      default: o.alu = 32'd0;
    endcase
    o.zero   = (o.alu == 32'd0);
    o.add    = v.npc + v.se * 32'd4;
    o.rdata2 = v.rd2;
    o.wreg   = v.exe[3] ? v.rd : v.rt;
    o.m      = v.mem;
    o.wb     = v.wb;
`ifdef EX_OVERFLOW_EN
    o.ovf = ovf;
    if (ovf) o.wb[1] = 1'b0;
`else
    o.ovf = 1'b0;
`endif
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic s, input in_t v);
    rst = r; ex_flush = f; ex_stall = s;
    id_ex_wb = v.wb; id_ex_mem = v.mem; id_ex_execute = v.exe; id_ex_npc = v.npc;
    id_ex_readdat1 = v.rd1; id_ex_readdat2 = v.rd2; id_ex_sign_ext = v.se;
    id_ex_instr_bits_20_16 = v.rt; id_ex_instr_bits_15_11 = v.rd;
  endtask

  // Apply one cycle and advance the expected EX/MEM state
  task automatic step(input logic r, input logic f, input logic s, input in_t v);
    out_t n;
    drive(r, f, s, v);
    @(posedge clk);
    if (r) begin
      exp_q = '{2'b00, 3'b000, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0};
    end else if (f) begin
      n = model(v); n.wb = 2'b00; n.m = 3'b000; n.ovf = 1'b0; exp_q = n;
    end else if (!s) begin
      exp_q = model(v);
    end
    #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".wb"}, {30'd0, ex_mem_wb}, {30'd0, exp_q.wb});
    chk({tag, ".m"}, {29'd0, ex_mem_m}, {29'd0, exp_q.m});
    chk({tag, ".add"}, ex_mem_add_result, exp_q.add);
    chk({tag, ".zero"}, {31'd0, ex_mem_zero}, {31'd0, exp_q.zero});
    chk({tag, ".alu"}, ex_mem_alu_result, exp_q.alu);
    chk({tag, ".rdata2"}, ex_mem_rdata2, exp_q.rdata2);
    chk({tag, ".wreg"}, {27'd0, ex_mem_write_reg}, {27'd0, exp_q.wreg});
`ifdef EX_OVERFLOW_EN
    chk({tag, ".ovf"}, {31'd0, ex_mem_overflow}, {31'd0, exp_q.ovf});
`endif
  endtask

  initial begin
    in_t v;
    //              wb     mem     exe      npc           rd1           rd2           se            rt     rd       alu           zero  wreg   add
    vecs[0]  = '{'{2'b10, 3'b000, 4'b1100, 32'h00000100, 32'h11111111, 32'h22222222, 32'h00001820, 5'd2, 5'd3},  32'h33333333, 1'b0, 5'd3,  32'h00006180};
    vecs[1]  = '{'{2'b11, 3'b010, 4'b0001, 32'h00000200, 32'h11111111, 32'h00000000, 32'hFFFFFFF8, 5'd4, 5'd31}, 32'h11111109, 1'b0, 5'd4,  32'h000001E0};
    vecs[2]  = '{'{2'b00, 3'b100, 4'b0010, 32'h0000100C, 32'h22222222, 32'h22222222, 32'h00000004, 5'd6, 5'd0},  32'h00000000, 1'b1, 5'd6,  32'h0000101C};
    vecs[3]  = '{'{2'b10, 3'b000, 4'b1100, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'h0000002A, 5'd1, 5'd7},  32'h00000001, 1'b0, 5'd7,  32'h000000A8};
    vecs[4]  = '{'{2'b10, 3'b000, 4'b1100, 32'h00000000, 32'h00000001, 32'h00000002, 32'h00000022, 5'd1, 5'd7},  32'hFFFFFFFF, 1'b0, 5'd7,  32'h00000088};
    vecs[5]  = '{'{2'b10, 3'b000, 4'b1100, 32'h00000000, 32'h00000005, 32'h00000005, 32'h0000003F, 5'd1, 5'd7},  32'h00000000, 1'b1, 5'd7,  32'h000000FC};
    vecs[6]  = '{'{2'b10, 3'b000, 4'b1110, 32'h00000000, 32'h00000003, 32'h00000004, 32'h00000020, 5'd1, 5'd9},  32'h00000000, 1'b1, 5'd9,  32'h00000080};
    vecs[7]  = '{'{2'b10, 3'b000, 4'b1100, 32'h00000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000024, 5'd1, 5'd10}, 32'hF000F000, 1'b0, 5'd10, 32'h00000090};
    vecs[8]  = '{'{2'b10, 3'b000, 4'b1100, 32'h00000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000025, 5'd1, 5'd11}, 32'hFFF0FFF0, 1'b0, 5'd11, 32'h00000094};
    vecs[9]  = '{'{2'b10, 3'b000, 4'b1100, 32'h00000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000027, 5'd1, 5'd12}, 32'h000F000F, 1'b0, 5'd12, 32'h0000009C};
    vecs[10] = '{'{2'b00, 3'b100, 4'b0010, 32'hFFFFFFFC, 32'h00000001, 32'h00000001, 32'h00000002, 5'd8, 5'd0},  32'h00000000, 1'b1, 5'd8,  32'h00000004};
    vecs[11] = '{'{2'b10, 3'b000, 4'b0000, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'd13, 5'd0}, 32'h00000000, 1'b1, 5'd13, 32'h00000000};

    step(1'b1, 1'b0, 1'b0, vecs[0].in);
    chk_all("reset");

    // Directed table against hand-derived values
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b0, vecs[i].in);
      chk($sformatf("vec%0d.alu", i), ex_mem_alu_result, vecs[i].e_alu);
      chk($sformatf("vec%0d.zero", i), {31'd0, ex_mem_zero}, {31'd0, vecs[i].e_zero});
      chk($sformatf("vec%0d.wreg", i), {27'd0, ex_mem_write_reg}, {27'd0, vecs[i].e_wreg});
      chk($sformatf("vec%0d.add", i), ex_mem_add_result, vecs[i].e_add);
      chk($sformatf("vec%0d.wb", i), {30'd0, ex_mem_wb}, {30'd0, vecs[i].in.wb});
      chk($sformatf("vec%0d.m", i), {29'd0, ex_mem_m}, {29'd0, vecs[i].in.mem});
      chk($sformatf("vec%0d.rdata2", i), ex_mem_rdata2, vecs[i].in.rd2);
    end

    // Stall holds, flush beats stall
    step(1'b0, 1'b0, 1'b0, vecs[0].in);
    step(1'b0, 1'b0, 1'b1, vecs[1].in);
    chk("stall.alu", ex_mem_alu_result, 32'h33333333);
    chk("stall.wreg", {27'd0, ex_mem_write_reg}, 32'd3);
    chk("stall.wb", {30'd0, ex_mem_wb}, 32'd2);
    step(1'b0, 1'b1, 1'b1, vecs[1].in);
    chk("flush.wb", {30'd0, ex_mem_wb}, 32'd0);
    chk("flush.m", {29'd0, ex_mem_m}, 32'd0);
    chk("flush.alu", ex_mem_alu_result, 32'h11111109);
    chk("flush.wreg", {27'd0, ex_mem_write_reg}, 32'd4);

    // Reset mid-stream, then resume
    step(1'b1, 1'b1, 1'b0, vecs[2].in);
    chk_all("rst_mid");
    chk("rst_mid.alu_const", ex_mem_alu_result, 32'd0);
    step(1'b0, 1'b0, 1'b0, vecs[0].in);
    chk("post_rst.alu", ex_mem_alu_result, 32'h33333333);
    chk("post_rst.wb", {30'd0, ex_mem_wb}, 32'd2);

`ifdef EX_OVERFLOW_EN
    v = vecs[0].in; v.rd1 = 32'h7FFFFFFF; v.rd2 = 32'h00000001;
    step(1'b0, 1'b0, 1'b0, v);
    chk("ovf.flag", {31'd0, ex_mem_overflow}, 32'd1);
    chk("ovf.wb", {30'd0, ex_mem_wb}, 32'd0);
    chk("ovf.alu", ex_mem_alu_result, 32'h80000000);
    step(1'b0, 1'b0, 1'b1, vecs[1].in);
    chk("ovf.hold", {31'd0, ex_mem_overflow}, 32'd1);
    step(1'b0, 1'b1, 1'b0, v);
    chk("ovf.flush", {31'd0, ex_mem_overflow}, 32'd0);
`endif

    // Randomized run against the reference model
    for (int i = 0; i < 600; i++) begin
      logic [5:0] fl [7];
      fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F};
      v.wb  = 2'($urandom);
      v.mem = 3'($urandom);
      v.exe = 4'($urandom);
      v.npc = $urandom;
      v.rd1 = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF + 32'($urandom_range(0, 2)) : $urandom;
      v.rd2 = ($urandom_range(0, 3) == 0) ? v.rd1 : $urandom;
      v.se  = $urandom;
      if ($urandom_range(0, 3) != 0) v.se[5:0] = fl[$urandom_range(0, 6)];
      v.rt  = 5'($urandom);
      v.rd  = 5'($urandom);
      step($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, v);
      chk_all($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
